// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stall/flush controller for the 5-stage MIPS pipeline (F, D, E, M, W).
//
// The D-stage instruction stalls in two cases:
//   * it reads a register that an E or M instruction produces too late.
//     Tuse/Tnew are compared per source operand.
//   * it touches HI/LO while a mult/div is still in flight.
// The multi-cycle HI/LO busy counter is kept here.
// On a stall, PC and F/D hold, and D/E is loaded with a bubble.
// E/M is never held.
//
// Optional build macro: HAZARD_STALL_STATS_EN
//   When defined, adds two saturating 32-bit statistics outputs:
//   stall_cnt (cycles with stall=1) and md_stall_cnt (cycles stalled on HI/LO).
//
// Parameters:
//   MULT_CYCLES  busy cycles after mult/multu issues from E
//   DIV_CYCLES   busy cycles after div/divu issues from E
//   CNT_W        busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rs_D, rt_D          source register fields of the D instruction
//   tuse_rs_D/rt_D      cycles until the operand is needed (3 = never)
//   dst_E, tnew_E       E destination (0 = none) and cycles until its result
//   dst_M, tnew_M       M destination and cycles until its result
//   md_start_E          mult/div is issuing from E this cycle
//   md_div_E            1 = div/divu, 0 = mult/multu
//   md_use_D            D instruction reads or writes HI/LO
//   stall               D-stage stall this cycle
//   pc_en, fd_en        PC and F/D register enables (= !stall)
//   de_clr              insert bubble into D/E (= stall)
//   em_en               E/M enable, always 1
//   md_busy             HI/LO operation in flight
//   stall_cnt           (optional) saturating count of stall cycles
//   md_stall_cnt        (optional) saturating count of HI/LO stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs_D,
   input  logic [1:0]  tuse_rt_D,
   input  logic [4:0]  dst_E,
   input  logic [1:0]  tnew_E,
   input  logic [4:0]  dst_M,
   input  logic [1:0]  tnew_M,
   input  logic        md_start_E,
   input  logic        md_div_E,
   input  logic        md_use_D,
   output logic        stall,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_clr,
   output logic        em_en,
   output logic        md_busy
`ifdef HAZARD_STALL_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt
`endif
);

   localparam logic [1:0]       TUSE_NEVER = 2'd3;
   localparam logic [CNT_W-1:0] CNT_MULT   = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DIV    = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   // -----------------------------------------------------------------------
   // Register hazards.
   // Both source operands use the same check, so they are packed into
   // two-entry arrays: entry 0 is rs and entry 1 is rt.
   // -----------------------------------------------------------------------
   logic [1:0][4:0] src_addr;
   logic [1:0][1:0] src_tuse;
   logic [1:0]      src_stall;

   assign src_addr = {rt_D, rs_D};
   assign src_tuse = {tuse_rt_D, tuse_rs_D};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic hit_e;
         logic hit_m;
         logic used;

         // The operand is needed sooner than the producer can supply it.
         assign hit_e = (src_addr[gi] == dst_E) && (src_tuse[gi] < tnew_E);
         assign hit_m = (src_addr[gi] == dst_M) && (src_tuse[gi] < tnew_M);

         // $0 is hard-wired to zero, so a "write" to it is never a real
         // dependency. tuse=3 already fails the compare because tnew<=2.
         // The explicit guard keeps that true even if tnew is out of range.
         assign used = (src_addr[gi] != 5'd0) && (src_tuse[gi] != TUSE_NEVER);

         assign src_stall[gi] = used && (hit_e || hit_m);
      end
   endgenerate

   // -----------------------------------------------------------------------
   // HI/LO busy counter.
   // The counter loads only from idle. A start that arrives while busy
   // cannot happen, because D is stalled. If it does happen, it is dropped
   // so the current operation keeps counting down normally.
   // -----------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             cnt_idle;

   assign cnt_idle = (cnt_reg == CNT_ZERO);

   always_comb begin
      cnt_next = cnt_reg;
      if (reset) begin
         cnt_next = CNT_ZERO;
      end else if (md_start_E && cnt_idle) begin
         cnt_next = md_div_E ? CNT_DIV : CNT_MULT;
      end else if (!cnt_idle) begin
         cnt_next = cnt_reg - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      cnt_reg <= cnt_next;
   end

   // -----------------------------------------------------------------------
   // Stall generation.
   // The issue cycle counts as busy, so md_busy covers 1 + N cycles.
   // During reset, every stall source is masked. This lets the front end
   // run freely, and releases any pending HI/LO stall in the reset cycle.
   // -----------------------------------------------------------------------
   logic md_busy_raw;
   logic stall_md;
   logic stall_reg_hz;
   logic stall_int;

   assign md_busy_raw  = md_start_E || !cnt_idle;
   assign stall_md     = !reset && md_use_D && md_busy_raw;
   assign stall_reg_hz = !reset && (|src_stall);
   assign stall_int    = stall_reg_hz || stall_md;

   assign stall   = stall_int;
   assign pc_en   = !stall_int;
   assign fd_en   = !stall_int;
   assign de_clr  = stall_int;
   assign em_en   = 1'b1;
   assign md_busy = !reset && md_busy_raw;

`ifdef HAZARD_STALL_STATS_EN
   // -----------------------------------------------------------------------
   // Saturating statistics counters.
   // They stop at the maximum value, so a long run cannot wrap back to a
   // misleadingly small number.
   // -----------------------------------------------------------------------
   localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

   logic [31:0] stall_cnt_reg;
   logic [31:0] stall_cnt_next;
   logic [31:0] md_stall_cnt_reg;
   logic [31:0] md_stall_cnt_next;

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (reset) begin
         stall_cnt_next = 32'd0;
      end else if (stall_int && (stall_cnt_reg != STAT_MAX)) begin
         stall_cnt_next = stall_cnt_reg + 32'd1;
      end
   end

   always_comb begin
      md_stall_cnt_next = md_stall_cnt_reg;
      if (reset) begin
         md_stall_cnt_next = 32'd0;
      end else if (stall_md && (md_stall_cnt_reg != STAT_MAX)) begin
         md_stall_cnt_next = md_stall_cnt_reg + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      stall_cnt_reg    <= stall_cnt_next;
      md_stall_cnt_reg <= md_stall_cnt_next;
   end

   assign stall_cnt    = stall_cnt_reg;
   assign md_stall_cnt = md_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed testbench for pipe_hazard_ctrl. Expected values are worked out by
// hand for each vector. Inputs change 1 time unit after a rising edge;
// outputs are sampled 2 time units later, well before the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] rs_D;
   logic [4:0] rt_D;
   logic [1:0] tuse_rs_D;
   logic [1:0] tuse_rt_D;
   logic [4:0] dst_E;
   logic [1:0] tnew_E;
   logic [4:0] dst_M;
   logic [1:0] tnew_M;
   logic       md_start_E;
   logic       md_div_E;
   logic       md_use_D;
   logic       stall;
   logic       pc_en;
   logic       fd_en;
   logic       de_clr;
   logic       em_en;
   logic       md_busy;
`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] stall_cnt;
   logic [31:0] md_stall_cnt;
`endif

   int n_total;
   int n_pass;

   pipe_hazard_ctrl #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10),
      .CNT_W      (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rs_D       (rs_D),
      .rt_D       (rt_D),
      .tuse_rs_D  (tuse_rs_D),
      .tuse_rt_D  (tuse_rt_D),
      .dst_E      (dst_E),
      .tnew_E     (tnew_E),
      .dst_M      (dst_M),
      .tnew_M     (tnew_M),
      .md_start_E (md_start_E),
      .md_div_E   (md_div_E),
      .md_use_D   (md_use_D),
      .stall      (stall),
      .pc_en      (pc_en),
      .fd_en      (fd_en),
      .de_clr     (de_clr),
      .em_en      (em_en),
      .md_busy    (md_busy)
`ifdef HAZARD_STALL_STATS_EN
      ,
      .stall_cnt    (stall_cnt),
      .md_stall_cnt (md_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value, count it, and print a line for the transaction.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-22s got=%0h", tag, got);
      end else begin
         $display("FAIL %-22s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let the combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   // Return all inputs to an idle pipeline with no hazards.
   task automatic idle_inputs();
      rs_D = 5'd0;       rt_D = 5'd0;
      tuse_rs_D = 2'd3;  tuse_rt_D = 2'd3;
      dst_E = 5'd0;      tnew_E = 2'd0;
      dst_M = 5'd0;      tnew_M = 2'd0;
      md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
   endtask

   // Check the stall and all of its derived enables together.
   task automatic check_stall(input string tag, input logic exp);
      check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp});
      check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, !exp});
      check({tag, ".fd_en"}, {31'd0, fd_en}, {31'd0, !exp});
      check({tag, ".de_clr"}, {31'd0, de_clr}, {31'd0, exp});
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b1;
      idle_inputs();
      tick();

      // Reset cycle: outputs are forced regardless of hazardous inputs.
      rs_D = 5'd1; tuse_rs_D = 2'd0; dst_E = 5'd1; tnew_E = 2'd2;
      md_start_E = 1'b1; md_use_D = 1'b1;
      settle();
      check_stall("rst_forced", 1'b0);
      check("rst_md_busy", {31'd0, md_busy}, 32'd0);
      check("rst_em_en", {31'd0, em_en}, 32'd1);
      tick();
      // The start pulse during reset must not have loaded the counter.
      reset = 1'b0;
      idle_inputs();
      settle();
      check_stall("post_rst", 1'b0);
      check("post_rst_busy", {31'd0, md_busy}, 32'd0);
      tick();

      // lw $1 in E, add reading $1 in D: the load-use hazard stalls.
      rs_D = 5'd1; tuse_rs_D = 2'd1; dst_E = 5'd1; tnew_E = 2'd2;
      settle();
      check_stall("lw_use_E", 1'b1);
      tick();
      // A bubble is now in E and lw is in M with tnew=1: tuse 1 < 1 is false.
      dst_E = 5'd0; tnew_E = 2'd0; dst_M = 5'd1; tnew_M = 2'd1;
      settle();
      check_stall("lw_use_M", 1'b0);
      tick();

      // $0 is exempt even when dst matches and timing would conflict.
      idle_inputs();
      rs_D = 5'd0; tuse_rs_D = 2'd0; dst_E = 5'd0; tnew_E = 2'd2;
      settle();
      check_stall("zero_reg", 1'b0);
      tick();
      // tuse=3 never stalls.
      rs_D = 5'd5; tuse_rs_D = 2'd3; dst_E = 5'd5; tnew_E = 2'd2;
      settle();
      check_stall("tuse_never", 1'b0);
      tick();
      // rt conflict with E: tuse 0 < tnew 1.
      idle_inputs();
      rt_D = 5'd7; tuse_rt_D = 2'd0; dst_E = 5'd7; tnew_E = 2'd1;
      settle();
      check_stall("rt_hz_E", 1'b1);
      tick();
      // Equal timing is forwardable: tuse 1, tnew 1.
      tuse_rt_D = 2'd1;
      settle();
      check_stall("rt_equal", 1'b0);
      tick();

      // mult issues from E while mflo sits in D:
      // busy and stall for 6 cycles, released on cycle 7.
      idle_inputs();
      for (int i = 0; i < 7; i++) begin
         md_start_E = (i == 0); md_div_E = 1'b0; md_use_D = 1'b1;
         settle();
         check($sformatf("mult_busy_c%0d", i), {31'd0, md_busy}, {31'd0, (i < 6)});
         check($sformatf("mult_stall_c%0d", i), {31'd0, stall}, {31'd0, (i < 6)});
         tick();
      end

      // div: busy for 11 cycles with nothing waiting in D.
      idle_inputs();
      for (int i = 0; i < 12; i++) begin
         md_start_E = (i == 0); md_div_E = 1'b1; md_use_D = 1'b0;
         settle();
         check($sformatf("div_busy_c%0d", i), {31'd0, md_busy}, {31'd0, (i <= 10)});
         check($sformatf("div_nostall_c%0d", i), {31'd0, stall}, 32'd0);
         tick();
      end

      // div again, with mfhi waiting in D.
      // Reset is asserted in cycle 7 (cnt=4); cycle 8 must already be idle.
      idle_inputs();
      for (int i = 0; i < 9; i++) begin
         md_start_E = (i == 0); md_div_E = 1'b1; md_use_D = 1'b1;
         reset = (i == 7);
         settle();
         check($sformatf("divrst_stall_c%0d", i), {31'd0, stall}, {31'd0, (i < 7)});
         check($sformatf("divrst_busy_c%0d", i), {31'd0, md_busy}, {31'd0, (i < 7)});
         tick();
      end
      reset = 1'b0;

      // Two hazards at once: an rt conflict with M plus a mult in flight.
      // The md stall ends after cycle 5, but the rt hazard holds the stall
      // until M is cleared in cycle 8.
      idle_inputs();
      for (int i = 0; i < 9; i++) begin
         md_start_E = (i == 0); md_div_E = 1'b0; md_use_D = 1'b1;
         rt_D = 5'd3; tuse_rt_D = 2'd0;
         dst_M = (i < 8) ? 5'd3 : 5'd0; tnew_M = 2'd1;
         settle();
         check_stall($sformatf("dual_c%0d", i), (i < 8));
         tick();
      end

`ifdef HAZARD_STALL_STATS_EN
      // Statistics: 3 load-use stall cycles, then a 6-cycle mult stall.
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check("stat_rst", stall_cnt, 32'd0);
      check("md_stat_rst", md_stall_cnt, 32'd0);
      for (int i = 0; i < 3; i++) begin
         rs_D = 5'd1; tuse_rs_D = 2'd0; dst_E = 5'd1; tnew_E = 2'd2;
         tick();
      end
      idle_inputs();
      tick();
      for (int i = 0; i < 7; i++) begin
         md_start_E = (i == 0); md_use_D = 1'b1;
         tick();
      end
      idle_inputs();
      settle();
      check("stat_stall_cnt", stall_cnt, 32'd9);
      check("stat_md_stall_cnt", md_stall_cnt, 32'd6);

      // Saturation: start near the maximum and stall for 3 cycles.
      force dut.stall_cnt_reg = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_reg;
      for (int i = 0; i < 3; i++) begin
         rs_D = 5'd1; tuse_rs_D = 2'd0; dst_E = 5'd1; tnew_E = 2'd2;
         tick();
      end
      idle_inputs();
      settle();
      check("stat_saturate", stall_cnt, 32'hFFFF_FFFF);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Safety net: if the sequence above stalls, fail instead of hanging.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline.
- Takes pre-decoded Tuse/Tnew and register-address info from the D, E and M stages, plus mult/div issue info.
- Generates the enables for the PC and F/D registers, the clear for the D/E register, and the E/M enable.
- Owns the multi-cycle HI/LO (mult/div) busy counter, so mfhi/mflo/mthi/mtlo/mult/div in D wait for an in-flight operation.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after div/divu issues from E.
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- tuse_rs_D  in  2  cycles until rs is needed (0..2); 3 = never used.
- tuse_rt_D  in  2  same for rt.
- dst_E  in  5  destination register of the E instruction; 0 = none.
- tnew_E  in  2  cycles until the E result is ready, counted from E (0..2).
- dst_M  in  5  destination register of the M instruction.
- tnew_M  in  2  cycles until the M result is ready (0..1).
- md_start_E  in  1  the instruction in E is mult/multu/div/divu (single-cycle pulse per instruction).
- md_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult.
- md_use_D  in  1  the instruction in D is mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- stall  out  1  a D-stage stall is active this cycle.
- pc_en  out  1  PC register enable (= !stall).
- fd_en  out  1  F/D register enable (= !stall).
- de_clr  out  1  load a bubble into D/E (= stall).
- em_en  out  1  E/M register enable; constant 1.
- md_busy  out  1  a HI/LO operation is in flight.

Behaviour:
- Clocking: all state changes on posedge clk; reset is synchronous, active-high, and dominates every other input.
- Register hazard (combinational):
  - stall_rs = (rs_D!=0) && ((rs_D==dst_E && tuse_rs_D<tnew_E) || (rs_D==dst_M && tuse_rs_D<tnew_M)).
  - stall_rt: same form using rt_D and tuse_rt_D.
  - tuse=3 never stalls. Register $0 never stalls, even when dst matches.
- Busy counter cnt (CNT_W bits), reset value 0:
  - md_start_E with cnt==0: load MULT_CYCLES or DIV_CYCLES per md_div_E.
  - Otherwise, if cnt!=0: decrement by 1.
  - md_start_E while cnt!=0 is impossible by construction (D stalls); if it occurs anyway, ignore it and keep decrementing.
  - cnt never wraps below 0.
- md_busy = md_start_E || (cnt!=0).
  - For mult, md_busy is high for 1+MULT_CYCLES consecutive cycles, starting in the issue cycle.
- stall_md = md_use_D && md_busy.
- stall = stall_rs || stall_rt || stall_md, combinational, same cycle as its inputs.
- Reset values:
  - cnt=0.
  - Outputs are driven from cnt and the inputs: stall=0 and md_busy=0 once the inputs are idle.
  - During the reset cycle the outputs are forced to pc_en=1, fd_en=1, de_clr=0, stall=0, md_busy=0, regardless of inputs.
- Reset mid-operation: cnt is cleared at the next edge and any pending md stall is released that cycle.
- Stall is held as long as the condition persists. A stall repeated across cycles re-inserts a bubble each cycle; E then drains (tnew_E=0), and D releases once dst_E/dst_M no longer conflict.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- Defined:
  - Adds output stall_cnt [31:0] (reset 0): increments by 1 every cycle stall=1, saturating at 32'hFFFFFFFF.
  - Adds output md_stall_cnt [31:0] (reset 0): counts cycles with stall_md=1, same saturation.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- lw $1 in E (dst_E=1, tnew_E=2), add using rs_D=1 (tuse_rs=1) in D -> stall=1, pc_en=0, de_clr=1 for 1 cycle; next cycle, with dst_M=1 and tnew_M=1, stall=0.
- dst_E=0, rs_D=0, tnew_E=2, tuse_rs=0 -> stall=0 ($0 exempt).
- mult in E (md_start_E=1, md_div_E=0), then mflo in D (md_use_D=1) held -> md_busy high 6 cycles, stall high 6 cycles, released on cycle 7.
- div issued -> cnt loads 10 and md_busy falls after 11 cycles; reset asserted at cnt=4 -> cnt=0 and stall=0 the next cycle.
- Simultaneous hazards: rt conflict with M (tnew_M=1, tuse_rt=0) plus md stall -> single stall; releases only when both clear.
- HAZARD_STALL_STATS_EN defined, 3-cycle lw stall plus 6-cycle md stall -> stall_cnt=9, md_stall_cnt=6; force stall_cnt near max -> it holds at 32'hFFFFFFFF.
